aud_codec_cfg_seq: RTL and testbench

- Power-up configuration sequencer for the audio codec that receives the serial audio stream (BCK/LRCK/DATA) from the audio DAC datapath.
- Walks a fixed 10-entry register table and writes each entry over a 2-wire I2C-style bus: START, slave-address byte, two data bytes, STOP.
- Checks ACK on every byte and retries on NACK.
- Asserts done only after the codec is fully configured; the DAC datapath is held in reset until then.

---
 rtl/aud_codec_cfg_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_aud_codec_cfg_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_codec_cfg_seq.sv
// Power-up configuration sequencer: writes a fixed register table to the audio
// codec over a 2-wire I2C-style bus, retrying NACKed entries, and flags done/err.
module aud_codec_cfg_seq #(
    parameter int unsigned CLK_DIV    = 46,
    parameter logic [7:0]  SLAVE_ADDR = 8'h34,
    parameter int unsigned TBL_LEN    = 10,
    parameter int unsigned RETRY_MAX  = 3,
    parameter int unsigned GAP_QTR    = 8
) (
    input  logic       iCLK_18_4,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iSDAT,
    output logic       oSCLK,
    output logic       oSDAT_OE,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oERR,
    output logic [3:0] oIDX
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = (GAP_QTR > 1) ? $clog2(GAP_QTR) : 1;
    localparam int unsigned RW = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      q_q, q_d;
    logic [1:0]      byte_q, byte_d;
    logic [2:0]      bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            nack_q, nack_d;
    logic [3:0]      idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            scl_q, scl_d;
    logic            oe_q, oe_d;
    logic            tick_c;
    logic [15:0]     word_c;
    logic [7:0]      tx_byte_c;

    // Register table entry {reg[6:0], data[8:0]}
    function automatic logic [15:0] tbl_word(input logic [3:0] i);
        case (i)
            4'd0:    tbl_word = 16'h1E00;
            4'd1:    tbl_word = 16'h0017;
            4'd2:    tbl_word = 16'h0217;
            4'd3:    tbl_word = 16'h0479;
            4'd4:    tbl_word = 16'h0679;
            4'd5:    tbl_word = 16'h0812;
            4'd6:    tbl_word = 16'h0A06;
            4'd7:    tbl_word = 16'h0C00;
            4'd8:    tbl_word = 16'h0E01;
            4'd9:    tbl_word = 16'h1201;
            default: tbl_word = 16'h0000;
        endcase
    endfunction

    assign tick_c = (state_q != S_IDLE) && (cnt_q == CW'(CLK_DIV - 1));

    // Next-state, counters, status flags and bus levels for the phase being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        retry_d = retry_q;
        nack_d  = nack_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        scl_d   = 1'b1;
        oe_d    = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = tick_c ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = 4'd0;
                    retry_d = '0;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
                    q_d     = 2'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_c) begin
                    if (q_q == 2'd3) begin
                        state_d = S_BIT;
                        q_d     = 2'd0;
                        byte_d  = 2'd0;
                        bit_d   = 3'd7;
                    end else begin
                        q_d = q_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (tick_c) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = S_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick_c) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd2) begin
                        nack_d = iSDAT;
                    end
                    if (q_q == 2'd3) begin
                        if (nack_q || byte_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_BIT;
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 3'd7;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (tick_c) begin
                    if (gap_q == GW'(GAP_QTR - 1)) begin
                        gap_d = '0;
                        q_d   = 2'd0;
                        if (nack_q && ((32'(retry_q) + 32'd1) < RETRY_MAX)) begin
                            retry_d = retry_q + RW'(1);
                            nack_d  = 1'b0;
                            state_d = S_START;
                        end else if (nack_q) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else if (idx_q == 4'(TBL_LEN - 1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            retry_d = '0;
                            state_d = S_START;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        word_c = tbl_word(idx_d);
        case (byte_d)
            2'd0:    tx_byte_c = SLAVE_ADDR;
            2'd1:    tx_byte_c = word_c[15:8];
            default: tx_byte_c = word_c[7:0];
        endcase

        case (state_d)
            S_START: begin
                scl_d = (q_d != 2'd3);
                oe_d  = (q_d != 2'd0);
            end
            S_BIT: begin
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
                oe_d  = ~tx_byte_c[bit_d];
            end
            S_ACK: begin
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
                oe_d  = 1'b0;
            end
            S_STOP: begin
                scl_d = (q_d != 2'd0);
                oe_d  = (q_d == 2'd0) || (q_d == 2'd1);
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= 2'd0;
            byte_q  <= 2'd0;
            bit_q   <= 3'd7;
            gap_q   <= '0;
            retry_q <= '0;
            nack_q  <= 1'b0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            retry_q <= retry_d;
            nack_q  <= nack_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
        end
    end

    assign oSCLK    = scl_q;
    assign oSDAT_OE = oe_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;
    assign oERR     = err_q;
    assign oIDX     = idx_q;

endmodule

// File: tb/tb_aud_codec_cfg_seq.sv
// Bench for aud_codec_cfg_seq: I2C slave model, bus monitor and byte scoreboard.
module tb_aud_codec_cfg_seq;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned ENTRY_CYC = 124 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sdat;
    logic       scl, sda_oe, busy, done, err;
    logic [3:0] idx;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] tbl [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                              16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1201};

    // Slave / monitor state
    logic       pull = 1'b0;
    int         mode = 0;
    logic       mon_chk = 1'b1;
    logic       mon_clr = 1'b0;
    int         txn_cnt = 0;
    int         bitcnt = 0;
    int         bif = 0;
    int         byte_cnt = 0;
    int         run = 1;
    logic       in_frame = 1'b0;
    logic       bit_rise = 1'b0;
    logic       pscl = 1'b1;
    logic       psda = 1'b1;
    logic [7:0] sh = 8'h00;
    logic [7:0] frame_reg = 8'h00;

    assign sdat = ~(sda_oe | pull);

    aud_codec_cfg_seq #(.CLK_DIV(CLK_DIV)) dut (
        .iCLK_18_4 (clk),
        .iRST      (rst),
        .iStart    (start),
        .iSDAT     (sdat),
        .oSCLK     (scl),
        .oSDAT_OE  (sda_oe),
        .oBUSY     (busy),
        .oDONE     (done),
        .oERR      (err),
        .oIDX      (idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_entry(input int i);
        logic [15:0] w;
        w = tbl[i];
        exp_q.push_back(8'h34);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic push_table();
        for (int i = 0; i < 10; i++) push_entry(i);
    endtask

    function automatic logic slave_ack();
        case (mode)
            1:       slave_ack = !(txn_cnt == 4 && bif == 0);
            2:       slave_ack = !(bif == 2 && frame_reg == 8'h08);
            default: slave_ack = 1'b1;
        endcase
    endfunction

    task automatic got_byte(input logic [7:0] b);
        logic [7:0] e;
        byte_cnt++;
        if (bif == 1) frame_reg = b;
        if (mon_chk) begin
            chk("byte_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bus_byte", b, e);
            end
        end
    endtask

    // Bus monitor and slave model, sampled mid-cycle away from the active edge
    always @(negedge clk) begin
        logic sda_now;
        if (mon_clr) begin
            txn_cnt = 0; bitcnt = 0; bif = 0; byte_cnt = 0; run = 1;
            in_frame = 1'b0; bit_rise = 1'b0; pull = 1'b0;
            pscl = scl; psda = ~(sda_oe | pull);
        end else begin
            sda_now = ~(sda_oe | pull);
            if (pscl && scl && (sda_now != psda)) begin
                if (!sda_now) begin
                    chk("start_legal", 32'(bitcnt == 0 && !in_frame), 1);
                    in_frame = 1'b1; txn_cnt++; bif = 0; bitcnt = 0; bit_rise = 1'b0;
                end else begin
                    chk("stop_legal", 32'(bitcnt == 1 && in_frame), 1);
                    in_frame = 1'b0; bitcnt = 0; bif = 0; bit_rise = 1'b0;
                end
            end
            if (!pscl && scl) begin
                if (in_frame) begin
                    chk("scl_low_len", run, 2 * CLK_DIV);
                    bit_rise = 1'b1;
                    if (bitcnt < 8) begin
                        sh = {sh[6:0], sda_now};
                        bitcnt++;
                        if (bitcnt == 8) got_byte(sh);
                    end else begin
                        bitcnt = 0;
                        bif++;
                    end
                end
                run = 1;
            end else if (pscl && !scl) begin
                if (bit_rise) chk("scl_high_len", run, 2 * CLK_DIV);
                bit_rise = 1'b0;
                pull = in_frame && (bitcnt == 8) && slave_ack();
                run = 1;
            end else begin
                run++;
            end
            pscl = scl;
            psda = sda_now;
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!busy) break;
        end
    endtask

    initial begin
        int cyc;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1);
        chk("rst_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_idx", idx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_scl", scl, 1);

        // Full table, slave ACKs everything
        mode = 0;
        clear_mon();
        push_table();
        pulse_start();
        chk("t1_busy_at_start", busy, 1);
        chk("t1_done_at_start", done, 0);
        run_until_idle(10 * ENTRY_CYC + 500, cyc);
        chk("t1_cycles", cyc, 10 * ENTRY_CYC);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_idx", idx, 9);
        chk("t1_txn", txn_cnt, 10);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Address byte of index 3 NACKed once
        mode = 1;
        clear_mon();
        for (int i = 0; i < 3; i++) push_entry(i);
        exp_q.push_back(8'h34);
        for (int i = 3; i < 10; i++) push_entry(i);
        pulse_start();
        chk("t2_done_cleared", done, 0);
        run_until_idle(12 * ENTRY_CYC, cyc);
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);
        chk("t2_txn", txn_cnt, 11);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Second data byte of index 5 always NACKed
        mode = 2;
        clear_mon();
        for (int i = 0; i < 5; i++) push_entry(i);
        for (int a = 0; a < 3; a++) push_entry(5);
        pulse_start();
        run_until_idle(12 * ENTRY_CYC, cyc);
        chk("t3_err", err, 1);
        chk("t3_done", done, 0);
        chk("t3_idx", idx, 5);
        chk("t3_busy", busy, 0);
        repeat (3 * ENTRY_CYC) @(posedge clk);
        #1;
        chk("t3_txn", txn_cnt, 8);
        chk("t3_bytes", byte_cnt, 24);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Reset during bit 4 of index 2's address byte
        mode = 0;
        clear_mon();
        mon_chk = 1'b0;
        pulse_start();
        n = 0;
        while (!(txn_cnt == 3 && bitcnt == 3) && n < 4 * ENTRY_CYC) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("t4_idx_before_rst", idx, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_rst_scl", scl, 1);
        chk("t4_rst_oe", sda_oe, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_idx", idx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_idle_scl", scl, 1);
        chk("t4_idle_busy", busy, 0);
        clear_mon();
        mon_chk = 1'b1;
        push_table();
        pulse_start();
        run_until_idle(10 * ENTRY_CYC + 500, cyc);
        chk("t4_cycles", cyc, 10 * ENTRY_CYC);
        chk("t4_done", done, 1);
        chk("t4_txn", txn_cnt, 10);
        chk("t4_queue_empty", exp_q.size(), 0);

        // iStart while busy is ignored; a fresh iStart after done reruns the table
        clear_mon();
        push_table();
        pulse_start();
        n = 0;
        while (txn_cnt != 5 && n < 6 * ENTRY_CYC) begin
            @(posedge clk);
            n++;
        end
        pulse_start();
        chk("t5_idx_after_restart", idx, 4);
        chk("t5_busy_after_restart", busy, 1);
        repeat (50) @(posedge clk);
        #1;
        chk("t5_idx_hold", idx, 4);
        run_until_idle(10 * ENTRY_CYC, cyc);
        chk("t5_done", done, 1);
        chk("t5_txn", txn_cnt, 10);
        chk("t5_queue_empty", exp_q.size(), 0);
        clear_mon();
        push_table();
        pulse_start();
        chk("t5_rerun_done_clr", done, 0);
        chk("t5_rerun_idx", idx, 0);
        chk("t5_rerun_busy", busy, 1);
        run_until_idle(10 * ENTRY_CYC + 500, cyc);
        chk("t5_rerun_cycles", cyc, 10 * ENTRY_CYC);
        chk("t5_rerun_done", done, 1);
        chk("t5_rerun_err", err, 0);
        chk("t5_rerun_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
